// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: datapath widths, load type codes and the
// hardwired zero register.
package mips_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [2:0] LT_W  = 3'd0;
    localparam logic [2:0] LT_H  = 3'd1;
    localparam logic [2:0] LT_HU = 3'd2;
    localparam logic [2:0] LT_B  = 3'd3;
    localparam logic [2:0] LT_BU = 3'd4;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/mem_wb_stage_if.sv
// Signal bundle between the memory stage / decode (master) and the MEM/WB
// stage (slave), including the register file write port it drives.
interface mem_wb_stage_if;
    import mips_pkg::*;

    // in_valid qualifies the in_* payload for one cycle; there is no ready,
    // the stage accepts every cycle and flush overrides in_valid.
    logic              in_valid;
    logic              flush;
    logic              in_reg_wr;
    logic              in_mem_to_reg;
    logic [2:0]        in_load_type;
    logic [1:0]        in_byte_off;
    logic [DATA_W-1:0] in_alu_result;
    logic [DATA_W-1:0] in_mem_rdata;
    logic [ADDR_W-1:0] in_dest;
    logic [ADDR_W-1:0] id_rs;
    logic [ADDR_W-1:0] id_rt;

    logic              wr;
    logic [ADDR_W-1:0] addr3;
    logic [DATA_W-1:0] data3;
    logic              fwd_rs_hit;
    logic              fwd_rt_hit;
    logic              align_err;
    logic [31:0]       retired;

    modport master (
        output in_valid, flush, in_reg_wr, in_mem_to_reg, in_load_type,
               in_byte_off, in_alu_result, in_mem_rdata, in_dest, id_rs, id_rt,
        input  wr, addr3, data3, fwd_rs_hit, fwd_rt_hit, align_err, retired
    );

    modport slave (
        input  in_valid, flush, in_reg_wr, in_mem_to_reg, in_load_type,
               in_byte_off, in_alu_result, in_mem_rdata, in_dest, id_rs, id_rt,
        output wr, addr3, data3, fwd_rs_hit, fwd_rt_hit, align_err, retired
    );
endinterface

// File: rtl/load_extend.sv
// Combinational load lane extraction (little-endian) with sign/zero extension
// and alignment check. Reserved load codes are treated as word loads.
module load_extend
    import mips_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [2:0]        load_type,
    input  logic [1:0]        byte_off,
    output logic [DATA_W-1:0] ext_data,
    output logic              misaligned
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[7:0];
        case (byte_off)
            2'd0: lane_b = rdata[7:0];
            2'd1: lane_b = rdata[15:8];
            2'd2: lane_b = rdata[23:16];
            2'd3: lane_b = rdata[31:24];
            default: lane_b = rdata[7:0];
        endcase
        lane_h = byte_off[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        ext_data   = rdata;
        misaligned = 1'b0;
        case (load_type)
            LT_B: ext_data = {{24{lane_b[7]}}, lane_b};
            LT_BU: ext_data = {24'd0, lane_b};
            LT_H: begin
                ext_data   = {{16{lane_h[15]}}, lane_h};
                misaligned = byte_off[0];
            end
            LT_HU: begin
                ext_data   = {16'd0, lane_h};
                misaligned = byte_off[0];
            end
            default: begin
                ext_data   = rdata;
                misaligned = (byte_off != 2'd0);
            end
        endcase
    end
endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects and extends the result ahead of capture,
// drives the register file write port, forwarding hits and retire count.
module mem_wb_stage
    import mips_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    mem_wb_stage_if.slave  bus
);
    logic [DATA_W-1:0] ext_data;
    logic              misaligned;
    logic [DATA_W-1:0] sel_data;
    logic              capture;
    logic              cap_err;

    logic              v_q;
    logic              reg_wr_q;
    logic              align_err_q;
    logic [ADDR_W-1:0] dest_q;
    logic [DATA_W-1:0] data_q;
    logic [31:0]       retired_q;

    load_extend u_load_extend (
        .rdata      (bus.in_mem_rdata),
        .load_type  (bus.in_load_type),
        .byte_off   (bus.in_byte_off),
        .ext_data   (ext_data),
        .misaligned (misaligned)
    );

    assign capture  = bus.in_valid & ~bus.flush;
    assign sel_data = bus.in_mem_to_reg ? ext_data : bus.in_alu_result;
    assign cap_err  = capture & bus.in_mem_to_reg & misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q         <= 1'b0;
            reg_wr_q    <= 1'b0;
            align_err_q <= 1'b0;
            dest_q      <= '0;
            data_q      <= '0;
            retired_q   <= '0;
        end else begin
            v_q         <= capture;
            align_err_q <= cap_err;
            if (capture) begin
                reg_wr_q <= bus.in_reg_wr;
                dest_q   <= bus.in_dest;
                data_q   <= sel_data;
            end
            // Counts what currently occupies the stage, as it leaves it.
            if (v_q & ~align_err_q)
                retired_q <= retired_q + 32'd1;
        end
    end

    assign bus.wr         = v_q & reg_wr_q & ~align_err_q & (dest_q != REG_ZERO);
    assign bus.addr3      = dest_q;
    assign bus.data3      = data_q;
    assign bus.align_err  = align_err_q;
    assign bus.retired    = retired_q;
    assign bus.fwd_rs_hit = bus.wr & (dest_q == bus.id_rs);
    assign bus.fwd_rt_hit = bus.wr & (dest_q == bus.id_rt);
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-to-writeback pipeline stage of the 32-bit MIPS core, sitting directly upstream of the register file write port. Each cycle it captures one retiring instruction from the memory stage. It selects the ALU result or the load data, extracting and extending the byte or halfword lane for loads. It then drives the register file write port (wr/addr3/data3) from a registered boundary and exposes a forwarding/hazard view to decode plus a retired-instruction counter.

## Interface
- DATA_W, 32: datapath width.
- ADDR_W, 5: register address width.

- clk  in  1  core clock; stage registers update on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  memory stage presents an instruction this cycle.
- flush  in  1  kill the instruction presented this cycle.
- in_reg_wr  in  1  instruction writes a register.
- in_mem_to_reg  in  1  1 = load data, 0 = ALU result.
- in_load_type  in  3  load width and sign code (package constants).
- in_byte_off  in  2  effective address bits [1:0].
- in_alu_result  in  DATA_W  ALU result.
- in_mem_rdata  in  DATA_W  aligned word from data memory.
- in_dest  in  ADDR_W  destination register.
- id_rs, id_rt  in  ADDR_W  decode-stage source registers.
- wr  out  1  register file write enable.
- addr3  out  ADDR_W  register file write address.
- data3  out  DATA_W  register file write data.
- fwd_rs_hit, fwd_rt_hit  out  1  the pending write targets id_rs or id_rt.
- align_err  out  1  registered misaligned-load flag for the current stage contents.
- retired  out  32  count of retired instructions.

## Operation
- Capture occurs at each rising clk. The stage valid bit (v) is set to in_valid & ~flush. Payload registers load only when in_valid & ~flush; otherwise they hold.
- Load extraction uses little-endian lanes: byte_off 0 selects bits [7:0] and byte_off 3 selects bits [31:24].
  - LT_B / LT_BU: selected byte, sign-extended or zero-extended.
  - LT_H / LT_HU: halfword at byte_off[1] (lane [15:0] or [31:16]), sign-extended or zero-extended.
  - LT_W: the full word.
  - Reserved codes 5–7 behave as LT_W.
- Misalignment rules:
  - LT_W with byte_off ≠ 0 is misaligned.
  - LT_H / LT_HU with byte_off[0] = 1 is misaligned.
  - The check applies only when in_mem_to_reg = 1.
  - On capture, misalignment sets align_err, and the write is suppressed.
- Write enable: wr = v & reg_wr & ~align_err & (dest ≠ 0). Writes to $0 are never issued.
- Register file outputs: addr3 = dest and data3 = the selected result, both driven from registers. Extension is computed before the capture register, so no combinational path runs from the in_* ports to data3.
- Forwarding: fwd_rs_hit = wr & (addr3 == id_rs), and likewise fwd_rt_hit. These hit signals are combinational.
- Retire counter: increments on every rising edge where v & ~align_err holds. A retired instruction counts even if it writes no register. The counter wraps from 0xFFFF_FFFF to 0.

## Timing
- Latency: an instruction presented in cycle N appears on wr/addr3/data3 in cycle N+1.
- The register file commits on the falling edge mid-cycle N+1, so decode reads in the second half of N+1 see the new value.
- Throughput: one instruction per cycle, with no backpressure. in_valid = 0 inserts a bubble (wr = 0 next cycle).
- Flush has priority over in_valid. The flushed instruction never writes, never counts, and never raises align_err.
- An errored instruction holds align_err = 1 for exactly its stage cycle. The flag clears when the next capture is not misaligned.
- Reset: while rst_n = 0, the following are forced immediately and held:
  - v, wr, align_err, fwd_*_hit: 0.
  - addr3: 0; data3: 0.
  - retired: 0.
- Reset mid-operation discards the stage contents; nothing is written. The first capture after rst_n rises is the first rising edge with rst_n = 1.

## Structure
- Shared package mips_pkg: LT_W = 3'd0, LT_H = 3'd1, LT_HU = 3'd2, LT_B = 3'd3, LT_BU = 3'd4, and the REG_ZERO constant.
- Sub-module load_extend: combinational; inputs rdata, load_type, byte_off; outputs ext_data and misaligned. It is instantiated once, ahead of the capture register.

## Test plan
- Word load: LT_W, off 0, rdata 0x8899AABB, dest 8 -> next cycle wr = 1, addr3 = 8, data3 = 0x8899AABB, retired + 1.
- Byte lanes:
  - LT_B, off 3, rdata 0x80FF_0000, dest 9 -> data3 = 0xFFFF_FF80.
  - LT_BU with the same stimulus -> data3 = 0x0000_0080.
  - LT_H, off 2, rdata 0x9000_1234 -> data3 = 0xFFFF_9000.
- Misaligned load: LT_W, off 2 -> wr = 0, align_err = 1 for one cycle, retired unchanged.
- $0 write: ALU result 0x5, dest 0, reg_wr 1 -> wr = 0, retired + 1.
- Forwarding and flush:
  - ALU result 0x1234, dest 5, with id_rs = 5 and id_rt = 6 in the following cycle -> fwd_rs_hit = 1, fwd_rt_hit = 0.
  - Same instruction with flush = 1 -> wr = 0 and no hit.
- Reset and wrap:
  - Preload retired to 0xFFFF_FFFF by forcing, retire one instruction -> counter reads 0.
  - Assert rst_n = 0 mid-stream -> wr, data3, and retired all 0 immediately, and no register changes on the next falling edge.
